// File: rtl/cpu_dec_pkg.sv
// cpu_dec_pkg: RV32I opcodes, decode enums and the registered decode packet type.
package cpu_dec_pkg;
   localparam logic [6:0] OP_ALU    = 7'h33;
   localparam logic [6:0] OP_ALUI   = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   typedef enum logic [3:0] {
      ALU_ADD = 4'h0, ALU_SLL = 4'h1, ALU_SLT = 4'h2, ALU_SLTU = 4'h3, ALU_XOR = 4'h4,
      ALU_SRL = 4'h5, ALU_OR = 4'h6, ALU_AND = 4'h7, ALU_SUB = 4'h8, ALU_SRA = 4'hD
   } alu_op_e;
   typedef enum logic [2:0] {
      CLS_ALU, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_UPPER
   } op_cls_e;
   typedef enum logic [2:0] {
      BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd4, BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7
   } brnch_cnd_e;
   typedef struct packed {
      alu_op_e    alu_op;
      brnch_cnd_e brnch_cnd;
      op_cls_e    op_cls;
      logic       illegal;
      logic       rd_we;
   } dec_pkt_t;
endpackage

// File: rtl/cpu_dec_if.sv
// cpu_dec_if: fetch, write-back, execute and packet signals of the decode stage.
interface cpu_dec_if #(parameter int XLEN = 32, NREG = 32, PC_W = 32);
   localparam int RADDR = $clog2(NREG);
   logic             dec_inst_vld, dec_inst_rdy, dec_kill, dec_wb_we, dec_ex_ld_vld, dec_ex_rdy;
   logic             dec_ex_vld, dec_rd_we, dec_illegal;
   logic [31:0]      dec_inst, dec_stall_cnt;
   logic [PC_W-1:0]  dec_inst_pc, dec_pc, dec_pc_4;
   logic [RADDR-1:0] dec_wb_addr, dec_ex_ld_rd, dec_rd;
   logic [XLEN-1:0]  dec_wb_data, dec_src1, dec_src2, dec_sx_imm;
   logic [3:0]       dec_alu_op;
   logic [2:0]       dec_brnch_cnd, dec_op_cls;
   modport master (
      output dec_inst_vld, dec_inst, dec_inst_pc, dec_kill, dec_wb_we, dec_wb_addr, dec_wb_data,
             dec_ex_ld_vld, dec_ex_ld_rd, dec_ex_rdy,
      input  dec_inst_rdy, dec_ex_vld, dec_src1, dec_src2, dec_pc, dec_pc_4, dec_sx_imm, dec_rd,
             dec_rd_we, dec_alu_op, dec_brnch_cnd, dec_op_cls, dec_illegal, dec_stall_cnt
   );
   modport slave (
      input  dec_inst_vld, dec_inst, dec_inst_pc, dec_kill, dec_wb_we, dec_wb_addr, dec_wb_data,
             dec_ex_ld_vld, dec_ex_ld_rd, dec_ex_rdy,
      output dec_inst_rdy, dec_ex_vld, dec_src1, dec_src2, dec_pc, dec_pc_4, dec_sx_imm, dec_rd,
             dec_rd_we, dec_alu_op, dec_brnch_cnd, dec_op_cls, dec_illegal, dec_stall_cnt
   );
endinterface

// File: rtl/cpu_dec_ibuf.sv
// cpu_dec_ibuf: instruction FIFO with wrap-around pointers, count and flush.
module cpu_dec_ibuf #(parameter int W = 64, DEPTH = 2) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   assign full  = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign dout  = mem[rp];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         mem <= '{default: '0};
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) mem[wp] <= din;
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
endmodule

// File: rtl/cpu_dec_p.sv
// cpu_dec_p: RV32I decode stage with instruction buffer, bypassed register file and load-use stall.
// Define CPU_DEC_PERF_EN to build the saturating hazard-stall counter.
module cpu_dec_p
   import cpu_dec_pkg::*;
#(parameter int XLEN = 32, NREG = 32, PC_W = 32, IBUF_DEPTH = 2) (
   input logic      dec_clk,
   input logic      dec_rst_n,
   cpu_dec_if.slave dec
);
   localparam int RADDR = $clog2(NREG);
   logic             full, empty, push, issue, hazard, rs1_use, rs2_use, vld;
   logic [31:0]      hin;
   logic [PC_W-1:0]  hpc, pc_q, pc4_q;
   logic [RADDR-1:0] rs1, rs2, rd, rd_q;
   logic [XLEN-1:0]  rf [NREG];
   logic [XLEN-1:0]  op1, op2, imm, imm_i, imm_s, imm_b, imm_u, imm_j, src1_q, src2_q, imm_q;
   dec_pkt_t         ctl, pkt;
   assign push = dec.dec_inst_vld && dec.dec_inst_rdy;
   assign dec.dec_inst_rdy = !full;
   cpu_dec_ibuf #(.W(PC_W + 32), .DEPTH(IBUF_DEPTH)) u_ibuf (
      .clk(dec_clk), .rst_n(dec_rst_n), .flush(dec.dec_kill), .push, .pop(issue),
      .din({dec.dec_inst_pc, dec.dec_inst}), .dout({hpc, hin}), .full, .empty
   );
   assign rs1   = RADDR'(hin[19:15]);
   assign rs2   = RADDR'(hin[24:20]);
   assign rd    = RADDR'(hin[11:7]);
   assign imm_i = XLEN'($signed(hin[31:20]));
   assign imm_s = XLEN'($signed({hin[31:25], hin[11:7]}));
   assign imm_b = XLEN'($signed({hin[31], hin[7], hin[30:25], hin[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({hin[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({hin[31], hin[19:12], hin[20], hin[30:21], 1'b0}));
   always_comb begin
      ctl = '0;
      ctl.alu_op = ALU_ADD;
      ctl.brnch_cnd = brnch_cnd_e'(hin[14:12]);
      imm = '0;
      case (hin[6:0])
         OP_ALU:    ctl.alu_op = alu_op_e'({hin[30], hin[14:12]});
         OP_ALUI:   begin
            ctl.op_cls = CLS_ALUI;
            ctl.alu_op = alu_op_e'({hin[14:12] == 3'b101 && hin[30], hin[14:12]});
            imm = imm_i;
         end
         OP_LOAD:   begin ctl.op_cls = CLS_LOAD;   imm = imm_i; end
         OP_STORE:  begin ctl.op_cls = CLS_STORE;  imm = imm_s; end
         OP_BRANCH: begin ctl.op_cls = CLS_BRANCH; imm = imm_b; end
         OP_JAL:    begin ctl.op_cls = CLS_JAL;    imm = imm_j; end
         OP_JALR:   begin ctl.op_cls = CLS_JALR;   imm = imm_i; end
         OP_LUI, OP_AUIPC: begin ctl.op_cls = CLS_UPPER; imm = imm_u; end
         default:   ctl.illegal = 1'b1;
      endcase
      ctl.rd_we = !ctl.illegal && rd != '0 && !(ctl.op_cls inside {CLS_STORE, CLS_BRANCH});
   end
   assign rs1_use = !ctl.illegal && ctl.op_cls inside {CLS_ALU, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JALR};
   assign rs2_use = !ctl.illegal && ctl.op_cls inside {CLS_ALU, CLS_STORE, CLS_BRANCH};
   assign hazard  = !empty && dec.dec_ex_ld_vld && dec.dec_ex_ld_rd != '0 &&
                    (rs1_use && rs1 == dec.dec_ex_ld_rd || rs2_use && rs2 == dec.dec_ex_ld_rd);
   assign issue   = !empty && !hazard && (!vld || dec.dec_ex_rdy);
   // Same-cycle write-back wins over the stored value so execute never sees stale operands.
   assign op1 = rs1 == '0 ? '0 : dec.dec_wb_we && dec.dec_wb_addr == rs1 ? dec.dec_wb_data : rf[rs1];
   assign op2 = rs2 == '0 ? '0 : dec.dec_wb_we && dec.dec_wb_addr == rs2 ? dec.dec_wb_data : rf[rs2];
   always_ff @(posedge dec_clk or negedge dec_rst_n)
      if (!dec_rst_n) rf <= '{default: '0};
      else if (dec.dec_wb_we && dec.dec_wb_addr != '0) rf[dec.dec_wb_addr] <= dec.dec_wb_data;
   always_ff @(posedge dec_clk or negedge dec_rst_n)
      if (!dec_rst_n) begin
         vld    <= 1'b0;
         pkt    <= '0;
         src1_q <= '0;
         src2_q <= '0;
         imm_q  <= '0;
         pc_q   <= '0;
         pc4_q  <= '0;
         rd_q   <= '0;
      end else if (dec.dec_kill) vld <= 1'b0;
      else if (issue) begin
         vld    <= 1'b1;
         pkt    <= ctl;
         src1_q <= op1;
         src2_q <= op2;
         imm_q  <= imm;
         pc_q   <= hpc;
         pc4_q  <= hpc + PC_W'(4);
         rd_q   <= rd;
      end else if (dec.dec_ex_rdy) vld <= 1'b0;
   assign dec.dec_ex_vld    = vld;
   assign dec.dec_src1      = src1_q;
   assign dec.dec_src2      = src2_q;
   assign dec.dec_sx_imm    = imm_q;
   assign dec.dec_pc        = pc_q;
   assign dec.dec_pc_4      = pc4_q;
   assign dec.dec_rd        = rd_q;
   assign dec.dec_rd_we     = pkt.rd_we;
   assign dec.dec_alu_op    = pkt.alu_op;
   assign dec.dec_brnch_cnd = pkt.brnch_cnd;
   assign dec.dec_op_cls    = pkt.op_cls;
   assign dec.dec_illegal   = pkt.illegal;
`ifdef CPU_DEC_PERF_EN
   logic [31:0] stall_cnt;
   always_ff @(posedge dec_clk or negedge dec_rst_n)
      if (!dec_rst_n) stall_cnt <= '0;
      else if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
   assign dec.dec_stall_cnt = stall_cnt;
`else
   assign dec.dec_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_cpu_dec_p.sv
// tb_cpu_dec_p: directed self-checking bench for the decode stage.
module tb_cpu_dec_p;
   import cpu_dec_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errs = 0;
   int   checks = 0;
   cpu_dec_if dif ();
   cpu_dec_p dut (.dec_clk(clk), .dec_rst_n(rst_n), .dec(dif));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [31:0] i, input logic [31:0] pc);
      dif.dec_inst_vld = 1'b1;
      dif.dec_inst     = i;
      dif.dec_inst_pc  = pc;
      tick();
      dif.dec_inst_vld = 1'b0;
   endtask
   task automatic chk_pkt(input string tag, input op_cls_e cls, input logic [4:0] rd,
                          input logic [31:0] imm, input logic we, input alu_op_e alu);
      chk({tag, ".vld"}, dif.dec_ex_vld, 1);
      chk({tag, ".cls"}, dif.dec_op_cls, cls);
      chk({tag, ".rd"}, dif.dec_rd, rd);
      chk({tag, ".imm"}, dif.dec_sx_imm, imm);
      chk({tag, ".rd_we"}, dif.dec_rd_we, we);
      chk({tag, ".alu"}, dif.dec_alu_op, alu);
   endtask
   initial begin
      dif.dec_inst_vld  = 1'b0;
      dif.dec_inst      = '0;
      dif.dec_inst_pc   = '0;
      dif.dec_kill      = 1'b0;
      dif.dec_wb_we     = 1'b0;
      dif.dec_wb_addr   = '0;
      dif.dec_wb_data   = '0;
      dif.dec_ex_ld_vld = 1'b0;
      dif.dec_ex_ld_rd  = '0;
      dif.dec_ex_rdy    = 1'b1;
      repeat (2) tick();
      chk("rst.rdy", dif.dec_inst_rdy, 1);
      chk("rst.vld", dif.dec_ex_vld, 0);
      chk("rst.src1", dif.dec_src1, 0);
      chk("rst.imm", dif.dec_sx_imm, 0);
      chk("rst.pc4", dif.dec_pc_4, 0);
      chk("rst.stall", dif.dec_stall_cnt, 0);
      rst_n = 1'b1;
      tick();
      // ADDI x1,x0,5 visible one edge after acceptance
      push(32'h0050_0093, 32'h100);
      chk("addi.lat", dif.dec_ex_vld, 0);
      tick();
      chk_pkt("addi", CLS_ALUI, 5'd1, 32'd5, 1'b1, ALU_ADD);
      chk("addi.pc", dif.dec_pc, 32'h100);
      chk("addi.pc4", dif.dec_pc_4, 32'h104);
      chk("addi.ill", dif.dec_illegal, 0);
      // ADD x3,x2,x2 decoded while x2 is written back
      push(32'h0021_01B3, 32'h104);
      dif.dec_wb_we = 1'b1; dif.dec_wb_addr = 5'd2; dif.dec_wb_data = 32'hDEAD_BEEF;
      tick();
      dif.dec_wb_we = 1'b0;
      chk_pkt("add", CLS_ALU, 5'd3, 32'd0, 1'b1, ALU_ADD);
      chk("add.src1", dif.dec_src1, 32'hDEAD_BEEF);
      chk("add.src2", dif.dec_src2, 32'hDEAD_BEEF);
      // SRAI then ADDI -1 back to back
      dif.dec_inst_vld = 1'b1; dif.dec_inst = 32'h4031_5213; dif.dec_inst_pc = 32'h108;
      tick();
      dif.dec_inst = 32'hFFF0_0093; dif.dec_inst_pc = 32'h10C;
      tick();
      dif.dec_inst_vld = 1'b0;
      chk_pkt("srai", CLS_ALUI, 5'd4, 32'h403, 1'b1, ALU_SRA);
      chk("srai.src1", dif.dec_src1, 32'hDEAD_BEEF);
      tick();
      chk_pkt("addim1", CLS_ALUI, 5'd1, 32'hFFFF_FFFF, 1'b1, ALU_ADD);
      // load-use on rs2 of SW x5,0(x6)
      dif.dec_ex_ld_vld = 1'b1; dif.dec_ex_ld_rd = 5'd5;
      push(32'h0053_2023, 32'h110);
      tick();
      chk("haz.vld1", dif.dec_ex_vld, 0);
      tick();
      tick();
      chk("haz.vld3", dif.dec_ex_vld, 0);
`ifdef CPU_DEC_PERF_EN
      chk("haz.stall", dif.dec_stall_cnt, 3);
`else
      chk("haz.stall", dif.dec_stall_cnt, 0);
`endif
      dif.dec_ex_ld_vld = 1'b0;
      tick();
      chk_pkt("sw", CLS_STORE, 5'd0, 32'd0, 1'b0, ALU_ADD);
      chk("sw.src2", dif.dec_src2, 0);
      // ALUI imm low bits match ld_rd but rs2 is unused: no stall
      dif.dec_ex_ld_vld = 1'b1; dif.dec_ex_ld_rd = 5'd5;
      push(32'h0050_0393, 32'h114);
      tick();
      dif.dec_ex_ld_vld = 1'b0;
      chk_pkt("addi7", CLS_ALUI, 5'd7, 32'd5, 1'b1, ALU_ADD);
      // execute backpressure with continuous fetch
      dif.dec_ex_rdy = 1'b0;
      dif.dec_inst_vld = 1'b1; dif.dec_inst = 32'h0010_0413; dif.dec_inst_pc = 32'h200;
      tick();
      chk("bp.hold1", dif.dec_rd, 7);
      chk("bp.rdy1", dif.dec_inst_rdy, 1);
      dif.dec_inst = 32'h0020_0493; dif.dec_inst_pc = 32'h204;
      tick();
      chk("bp.full", dif.dec_inst_rdy, 0);
      dif.dec_inst = 32'h0030_0513; dif.dec_inst_pc = 32'h208;
      tick();
      tick();
      chk("bp.hold4", dif.dec_rd, 7);
      chk("bp.pc4", dif.dec_pc, 32'h114);
      chk("bp.vld4", dif.dec_ex_vld, 1);
      dif.dec_ex_rdy = 1'b1;
      tick();
      chk_pkt("bp.i1", CLS_ALUI, 5'd8, 32'd1, 1'b1, ALU_ADD);
      chk("bp.i1pc", dif.dec_pc, 32'h200);
      chk("bp.rdy5", dif.dec_inst_rdy, 1);
      tick();
      dif.dec_inst_vld = 1'b0;
      chk("bp.i2rd", dif.dec_rd, 9);
      chk("bp.i2pc", dif.dec_pc, 32'h204);
      tick();
      chk("bp.i3rd", dif.dec_rd, 10);
      chk("bp.i3pc", dif.dec_pc, 32'h208);
      tick();
      chk("bp.drain", dif.dec_ex_vld, 0);
      // kill with full buffer and valid packet; write-back commits meanwhile
      dif.dec_ex_rdy = 1'b0;
      dif.dec_inst_vld = 1'b1; dif.dec_inst = 32'h00B0_0593; dif.dec_inst_pc = 32'h300;
      tick();
      dif.dec_inst = 32'h00C0_0613; dif.dec_inst_pc = 32'h304;
      tick();
      dif.dec_inst = 32'h00D0_0693; dif.dec_inst_pc = 32'h308;
      tick();
      chk("kill.full", dif.dec_inst_rdy, 0);
      chk("kill.pre_vld", dif.dec_ex_vld, 1);
      chk("kill.pre_rd", dif.dec_rd, 11);
      dif.dec_kill = 1'b1;
      dif.dec_wb_we = 1'b1; dif.dec_wb_addr = 5'd12; dif.dec_wb_data = 32'h55;
      tick();
      dif.dec_kill = 1'b0; dif.dec_inst_vld = 1'b0; dif.dec_wb_we = 1'b0; dif.dec_ex_rdy = 1'b1;
      chk("kill.vld", dif.dec_ex_vld, 0);
      chk("kill.rdy", dif.dec_inst_rdy, 1);
      tick();
      chk("kill.empty", dif.dec_ex_vld, 0);
      dif.dec_kill = 1'b1;
      push(32'h00E0_0713, 32'h30C);
      dif.dec_kill = 1'b0;
      tick();
      chk("kill.push", dif.dec_ex_vld, 0);
      push(32'h0006_06B3, 32'h310);
      tick();
      chk("kill.wb", dif.dec_src1, 32'h55);
      chk("kill.wbrd", dif.dec_rd, 13);
      // x0 is never written nor bypassed
      dif.dec_wb_we = 1'b1; dif.dec_wb_addr = 5'd0; dif.dec_wb_data = 32'h1234;
      push(32'h0000_01B3, 32'h314);
      tick();
      dif.dec_wb_we = 1'b0;
      chk("x0.src1", dif.dec_src1, 0);
      chk("x0.src2", dif.dec_src2, 0);
      push(32'h0000_007F, 32'h318);
      tick();
      chk("ill.vld", dif.dec_ex_vld, 1);
      chk("ill.flag", dif.dec_illegal, 1);
      chk("ill.rd_we", dif.dec_rd_we, 0);
      push(32'hFE00_1EE3, 32'h31C);
      tick();
      chk_pkt("bne", CLS_BRANCH, 5'd29, 32'hFFFF_FFFC, 1'b0, ALU_ADD);
      chk("bne.cnd", dif.dec_brnch_cnd, BR_NE);
      push(32'h0100_00EF, 32'h320);
      tick();
      chk_pkt("jal", CLS_JAL, 5'd1, 32'h10, 1'b1, ALU_ADD);
      chk("jal.pc4", dif.dec_pc_4, 32'h324);
      push(32'h1234_52B7, 32'h324);
      tick();
      chk_pkt("lui", CLS_UPPER, 5'd5, 32'h1234_5000, 1'b1, ALU_ADD);
`ifdef CPU_DEC_PERF_EN
      chk("stall.keep", dif.dec_stall_cnt, 3);
`else
      chk("stall.keep", dif.dec_stall_cnt, 0);
`endif
      // asynchronous reset mid-operation
      dif.dec_ex_rdy = 1'b0;
      push(32'h0050_0093, 32'h400);
      push(32'h0010_0413, 32'h404);
      push(32'h0020_0493, 32'h408);
      chk("mrst.pre_rdy", dif.dec_inst_rdy, 0);
      chk("mrst.pre_vld", dif.dec_ex_vld, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst.vld", dif.dec_ex_vld, 0);
      chk("mrst.rdy", dif.dec_inst_rdy, 1);
      chk("mrst.pc", dif.dec_pc, 0);
      chk("mrst.stall", dif.dec_stall_cnt, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
